// File: rtl/gpu_mem_arbiter.sv
// gpu_mem_arbiter: round-robin arbiter that shares one DDR command port
// between NREQ GPU memory clients and routes returning read beats back to
// the requester that issued each read, using an in-order tag FIFO.
//
// Handshakes (one rule for every port pair in this block):
//   requester k -> arbiter : a command transfers on a clock edge where
//                            i_reqCommand[k]=1 and o_reqBusy[k]=0.
//   arbiter -> DDR         : a command transfers on a clock edge where
//                            o_command=1 and i_busy=0.
//   DDR -> arbiter         : i_dataInValid is a strobe with no back-pressure;
//                            each beat is forwarded in the same cycle.
module gpu_mem_arbiter #(
   parameter int NREQ     = 4,
   parameter int TAGDEPTH = 8,
   parameter int IW       = 3
) (
   input  logic                i_clk,
   input  logic                i_nrst,
   input  logic [NREQ-1:0]     i_reqCommand,
   input  logic [2*NREQ-1:0]   i_reqCommandSize,
   input  logic [NREQ-1:0]     i_reqWrite,
   input  logic [15*NREQ-1:0]  i_reqAdr,
   input  logic [3*NREQ-1:0]   i_reqSubadr,
   input  logic [16*NREQ-1:0]  i_reqWriteMask,
   input  logic [256*NREQ-1:0] i_reqDataOut,
   output logic [NREQ-1:0]     o_reqBusy,
   output logic [NREQ-1:0]     o_reqDataInValid,
   output logic [255:0]        o_reqDataIn,
   output logic                o_command,
   input  logic                i_busy,
   output logic [1:0]          o_commandSize,
   output logic                o_write,
   output logic [14:0]         o_adr,
   output logic [2:0]          o_subadr,
   output logic [15:0]         o_writeMask,
   output logic [255:0]        o_dataOut,
   input  logic [255:0]        i_dataIn,
   input  logic                i_dataInValid,
   output logic                o_errOrphan,
   output logic                o_tagFull,
   output logic                o_dbgState
);

   localparam int AW = $clog2(TAGDEPTH);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } stateT;

   stateT state;
   stateT nextState;

   logic [IW-1:0]   grant;
   logic [IW-1:0]   rrPtr;
   logic [IW-1:0]   pick;
   logic [IW:0]     cand;
   logic            anyEligible;
   logic [NREQ-1:0] eligible;
   logic            accept;

   // Tag FIFO: one entry per outstanding read, holding the requester index
   // and the number of beats still owed to it (head entry counts down).
   logic [IW-1:0]   tagIdx   [TAGDEPTH];
   logic [1:0]      tagBeats [TAGDEPTH];
   logic [AW-1:0]   wrPtr;
   logic [AW-1:0]   rdPtr;
   logic [AW:0]     count;
   logic            tagEmpty;
   logic            beatValid;
   logic            push;
   logic            pop;
   logic            headDec;

   assign accept    = (state == ISSUE) && !i_busy;
   assign tagEmpty  = (count == '0);
   assign o_tagFull = (count == (AW+1)'(TAGDEPTH));
   assign beatValid = i_dataInValid && !tagEmpty;
   assign push      = accept && !o_write;
   assign pop       = beatValid && (tagBeats[rdPtr] == 2'd1);
   assign headDec   = beatValid && (tagBeats[rdPtr] != 2'd1);
   assign o_reqDataIn = i_dataIn;

   // A read is only eligible while a tag slot is free; writes never need one.
   always_comb begin
      eligible = '0;
      for (int k = 0; k < NREQ; k++) begin
         eligible[k] = i_reqCommand[k] && (i_reqWrite[k] || !o_tagFull);
      end
   end

   // Round-robin pick: first eligible index at or after rrPtr, wrapping.
   // Walking the offsets downwards lets the smallest offset win.
   always_comb begin
      pick        = '0;
      anyEligible = 1'b0;
      cand        = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = {1'b0, rrPtr} + (IW+1)'(i);
         if (cand >= (IW+1)'(NREQ)) begin
            cand = cand - (IW+1)'(NREQ);
         end
         for (int k = 0; k < NREQ; k++) begin
            if ((cand == (IW+1)'(k)) && eligible[k]) begin
               pick        = IW'(k);
               anyEligible = 1'b1;
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // FSM next-state logic: one grant per visit to IDLE, leave ISSUE on accept.
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (anyEligible) nextState = ISSUE;
         ISSUE:   if (!i_busy)     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // FSM outputs: command strobe and state visibility.
   always_comb begin
      o_command  = (state == ISSUE);
      o_dbgState = (state == ISSUE);
   end

   // Grant latch in IDLE; pointer moves past the winner only on acceptance.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         grant <= '0;
         rrPtr <= '0;
      end else begin
         if ((state == IDLE) && anyEligible) begin
            grant <= pick;
         end
         if (accept) begin
            rrPtr <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
         end
      end
   end

   // Forward the granted requester's live fields while issuing, zero otherwise.
   always_comb begin
      o_commandSize = '0;
      o_write       = 1'b0;
      o_adr         = '0;
      o_subadr      = '0;
      o_writeMask   = '0;
      o_dataOut     = '0;
      if (state == ISSUE) begin
         for (int k = 0; k < NREQ; k++) begin
            if (grant == IW'(k)) begin
               o_commandSize = i_reqCommandSize[2*k +: 2];
               o_write       = i_reqWrite[k];
               o_adr         = i_reqAdr[15*k +: 15];
               o_subadr      = i_reqSubadr[3*k +: 3];
               o_writeMask   = i_reqWriteMask[16*k +: 16];
               o_dataOut     = i_reqDataOut[256*k +: 256];
            end
         end
      end
   end

   // Busy back to requesters: only the granted one sees DDR's busy.
   always_comb begin
      o_reqBusy = '1;
      if (state == ISSUE) begin
         for (int k = 0; k < NREQ; k++) begin
            if (grant == IW'(k)) begin
               o_reqBusy[k] = i_busy;
            end
         end
      end
   end

   // Read-return strobe steered by the head tag, same cycle as the DDR beat.
   always_comb begin
      o_reqDataInValid = '0;
      if (beatValid) begin
         for (int k = 0; k < NREQ; k++) begin
            if (tagIdx[rdPtr] == IW'(k)) begin
               o_reqDataInValid[k] = 1'b1;
            end
         end
      end
   end

   // Tag FIFO pointers and occupancy; push and pop may coincide.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Tag FIFO storage; a push never targets the head slot while it is live.
   always_ff @(posedge i_clk) begin
      if (push) begin
         tagIdx[wrPtr]   <= grant;
         tagBeats[wrPtr] <= (o_commandSize == 2'b10) ? 2'd2 : 2'd1;
      end
      if (headDec) begin
         tagBeats[rdPtr] <= tagBeats[rdPtr] - 2'd1;
      end
   end

   // Sticky flag for read data that no outstanding tag can claim.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         o_errOrphan <= 1'b0;
      end else if (i_dataInValid && tagEmpty) begin
         o_errOrphan <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// tb_gpu_mem_arbiter: directed scenarios for gpu_mem_arbiter. Requester
// agents replay per-requester command lists; monitors compare every DDR
// command acceptance and every read-return beat against expectation queues
// filled by the scenarios in hand-computed order.
module tb_gpu_mem_arbiter;

   localparam int NREQ     = 4;
   localparam int TAGDEPTH = 8;
   localparam int IW       = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]     i_reqCommand;
   logic [2*NREQ-1:0]   i_reqCommandSize;
   logic [NREQ-1:0]     i_reqWrite;
   logic [15*NREQ-1:0]  i_reqAdr;
   logic [3*NREQ-1:0]   i_reqSubadr;
   logic [16*NREQ-1:0]  i_reqWriteMask;
   logic [256*NREQ-1:0] i_reqDataOut;
   logic [NREQ-1:0]     o_reqBusy;
   logic [NREQ-1:0]     o_reqDataInValid;
   logic [255:0]        o_reqDataIn;
   logic                o_command;
   logic                i_busy;
   logic [1:0]          o_commandSize;
   logic                o_write;
   logic [14:0]         o_adr;
   logic [2:0]          o_subadr;
   logic [15:0]         o_writeMask;
   logic [255:0]        o_dataOut;
   logic [255:0]        i_dataIn;
   logic                i_dataInValid;
   logic                o_errOrphan;
   logic                o_tagFull;
   logic                o_dbgState;

   gpu_mem_arbiter #(.NREQ(NREQ), .TAGDEPTH(TAGDEPTH), .IW(IW)) dut (
      .i_clk(clk), .i_nrst(rst_n),
      .i_reqCommand(i_reqCommand), .i_reqCommandSize(i_reqCommandSize),
      .i_reqWrite(i_reqWrite), .i_reqAdr(i_reqAdr), .i_reqSubadr(i_reqSubadr),
      .i_reqWriteMask(i_reqWriteMask), .i_reqDataOut(i_reqDataOut),
      .o_reqBusy(o_reqBusy), .o_reqDataInValid(o_reqDataInValid),
      .o_reqDataIn(o_reqDataIn), .o_command(o_command), .i_busy(i_busy),
      .o_commandSize(o_commandSize), .o_write(o_write), .o_adr(o_adr),
      .o_subadr(o_subadr), .o_writeMask(o_writeMask), .o_dataOut(o_dataOut),
      .i_dataIn(i_dataIn), .i_dataInValid(i_dataInValid),
      .o_errOrphan(o_errOrphan), .o_tagFull(o_tagFull), .o_dbgState(o_dbgState)
   );

   // ---------------- scoreboard state ----------------
   int nCompared = 0;
   int nMismatched = 0;
   logic [71:0] exp_q[$];   // {idx, write, size, adr, subadr, mask, dword}
   logic [34:0] ret_q[$];   // {idx, dword}

   // Per-requester command lists: item = {write, size, adr, subadr, mask, dword}
   logic [68:0] stimMem [NREQ][32];
   int stimWr [NREQ];
   int stimRd [NREQ];

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [68:0] mk(input logic w, input logic [1:0] sz, input logic [14:0] adr,
                                      input logic [2:0] sub, input logic [15:0] msk,
                                      input logic [31:0] dw);
      return {w, sz, adr, sub, msk, dw};
   endfunction

   function automatic bit stimEmpty();
      bit e = 1'b1;
      for (int k = 0; k < NREQ; k++) if (stimRd[k] != stimWr[k]) e = 1'b0;
      return e;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic enq(input int k, input logic [68:0] item);
      stimMem[k][stimWr[k] % 32] = item;
      stimWr[k]++;
   endtask

   task automatic expectCmd(input int k, input logic [68:0] item);
      logic [2:0] idx;
      idx = k[2:0];
      exp_q.push_back({idx, item});
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic beat(input logic [31:0] dw);
      i_dataIn = {8{dw}};
      i_dataInValid = 1'b1;
      @(posedge clk);
      #2;
      i_dataInValid = 1'b0;
      i_dataIn = '0;
   endtask

   task automatic clearBench();
      for (int k = 0; k < NREQ; k++) stimRd[k] = stimWr[k];
      exp_q.delete();
      ret_q.delete();
      i_busy = 1'b0;
      i_dataInValid = 1'b0;
      i_dataIn = '0;
   endtask

   task automatic waitIdle(input string name);
      bit done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         if (stimEmpty() && i_reqCommand == '0 && !o_command) done = 1'b1;
      end
      if (!done) begin
         nCompared++;
         nMismatched++;
         $display("FAIL %s: timeout waiting for idle, got busy expected idle", name);
      end
      @(posedge clk);
      #2;
   endtask

   // Returns at a falling edge with o_command high (or after a counted timeout).
   task automatic waitCommand(input string name);
      bit seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (o_command) seen = 1'b1;
      end
      if (!seen) begin
         nCompared++;
         nMismatched++;
         $display("FAIL %s: timeout, got o_command=0 expected 1", name);
      end
   endtask

   // ---------------- requester agents ----------------
   initial begin
      logic [NREQ-1:0] acc;
      logic [68:0] it;
      i_reqCommand = '0; i_reqCommandSize = '0; i_reqWrite = '0; i_reqAdr = '0;
      i_reqSubadr = '0; i_reqWriteMask = '0; i_reqDataOut = '0;
      for (int k = 0; k < NREQ; k++) begin
         stimWr[k] = 0;
         stimRd[k] = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < NREQ; k++) acc[k] = rst_n & i_reqCommand[k] & ~o_reqBusy[k];
         @(posedge clk);
         #1;
         for (int k = 0; k < NREQ; k++) begin
            if (acc[k] && stimRd[k] != stimWr[k]) stimRd[k]++;
            if (stimRd[k] != stimWr[k]) begin
               it = stimMem[k][stimRd[k] % 32];
               i_reqWrite[k]                = it[68];
               i_reqCommandSize[2*k +: 2]   = it[67:66];
               i_reqAdr[15*k +: 15]         = it[65:51];
               i_reqSubadr[3*k +: 3]        = it[50:48];
               i_reqWriteMask[16*k +: 16]   = it[47:32];
               i_reqDataOut[256*k +: 256]   = {8{it[31:0]}};
               i_reqCommand[k]              = 1'b1;
            end else begin
               i_reqCommand[k] = 1'b0;
            end
         end
      end
   end

   // ---------------- monitors ----------------
   // DDR command acceptance: the single low o_reqBusy bit names the winner.
   initial begin
      int zeros;
      int idx;
      logic [71:0] act;
      logic [71:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && o_command && !i_busy) begin
            zeros = 0;
            idx = 7;
            for (int k = 0; k < NREQ; k++) if (!o_reqBusy[k]) begin zeros++; idx = k; end
            if (zeros != 1) idx = 7;
            act = {idx[2:0], o_write, o_commandSize, o_adr, o_subadr, o_writeMask, o_dataOut[31:0]};
            if (exp_q.size() == 0) begin
               nCompared++;
               nMismatched++;
               $display("FAIL cmd_unexpected: got %0h expected no command", act);
            end else begin
               e = exp_q.pop_front();
               check("cmd_issue", act, e);
               check("cmd_data_hi", o_dataOut[255:224], e[31:0]);
            end
         end
      end
   end

   // Read-return beats: strobe must follow the issue order of reads.
   initial begin
      logic [34:0] r;
      logic [3:0] oh;
      forever begin
         @(negedge clk);
         if (rst_n && i_dataInValid) begin
            if (ret_q.size() > 0) begin
               r = ret_q.pop_front();
               oh = 4'b0001 << r[34:32];
               check("ret_strobe", o_reqDataInValid, oh);
               check("ret_data", o_reqDataIn[31:0], r[31:0]);
            end else begin
               check("orphan_strobe", o_reqDataInValid, 4'b0000);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scenarios ----------------
   initial begin
      logic [31:0] dws [17];
      logic [34:0] rets [17];
      i_busy = 1'b0;
      i_dataInValid = 1'b0;
      i_dataIn = '0;
      rst_n = 1'b0;

      // Reset state
      #12;
      check("rst_busy", o_reqBusy, 4'hF);
      check("rst_command", o_command, 0);
      check("rst_strobe", o_reqDataInValid, 0);
      check("rst_tagfull", o_tagFull, 0);
      check("rst_orphan", o_errOrphan, 0);
      check("rst_state", o_dbgState, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      tick(1);

      // Single read from requester 1, one-cycle issue latency
      enq(1, mk(1'b0, 2'b01, 15'h0123, 3'd5, 16'hFFFF, 32'hD00D0001));
      expectCmd(1, mk(1'b0, 2'b01, 15'h0123, 3'd5, 16'hFFFF, 32'hD00D0001));
      @(posedge clk);
      #2;
      @(negedge clk);
      check("lat_idle", o_command, 0);
      @(negedge clk);
      check("lat_issue", o_command, 1);
      check("lat_adr", o_adr, 15'h0123);
      waitIdle("single_issue");
      ret_q.push_back({3'd1, 32'hBEEF0001});
      beat(32'hBEEF0001);
      tick(1);
      check("single_no_orphan", o_errOrphan, 0);

      // Orphan: FIFO drained by the single beat above
      beat(32'hDEAD0000);
      tick(1);
      check("orphan_set", o_errOrphan, 1);
      tick(3);
      check("orphan_sticky", o_errOrphan, 1);
      rst_n = 1'b0;
      #1;
      check("orphan_cleared", o_errOrphan, 0);
      clearBench();
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Round robin: 0, 2, 3 held continuously, pointer starts at 0
      enq(0, mk(1'b1, 2'b00, 15'h0A00, 3'd0, 16'h000F, 32'h00000A00));
      enq(0, mk(1'b1, 2'b00, 15'h0A01, 3'd1, 16'h00F0, 32'h00000A01));
      enq(2, mk(1'b1, 2'b01, 15'h0C00, 3'd2, 16'h0F00, 32'h00000C00));
      enq(2, mk(1'b1, 2'b01, 15'h0C01, 3'd3, 16'hF000, 32'h00000C01));
      enq(3, mk(1'b1, 2'b11, 15'h0D00, 3'd4, 16'h1234, 32'h00000D00));
      enq(3, mk(1'b1, 2'b11, 15'h0D01, 3'd6, 16'h5678, 32'h00000D01));
      expectCmd(0, mk(1'b1, 2'b00, 15'h0A00, 3'd0, 16'h000F, 32'h00000A00));
      expectCmd(2, mk(1'b1, 2'b01, 15'h0C00, 3'd2, 16'h0F00, 32'h00000C00));
      expectCmd(3, mk(1'b1, 2'b11, 15'h0D00, 3'd4, 16'h1234, 32'h00000D00));
      expectCmd(0, mk(1'b1, 2'b00, 15'h0A01, 3'd1, 16'h00F0, 32'h00000A01));
      expectCmd(2, mk(1'b1, 2'b01, 15'h0C01, 3'd3, 16'hF000, 32'h00000C01));
      expectCmd(3, mk(1'b1, 2'b11, 15'h0D01, 3'd6, 16'h5678, 32'h00000D01));
      waitIdle("rr_issue");
      check("rr_all_issued", exp_q.size(), 0);

      // DDR stall: five busy cycles in ISSUE, accepted on the sixth
      i_busy = 1'b1;
      enq(1, mk(1'b0, 2'b01, 15'h0456, 3'd2, 16'hAAAA, 32'h57A11000));
      expectCmd(1, mk(1'b0, 2'b01, 15'h0456, 3'd2, 16'hAAAA, 32'h57A11000));
      waitCommand("stall_wait");
      for (int s = 0; s < 5; s++) begin
         if (s > 0) @(negedge clk);
         check("stall_command", o_command, 1);
         check("stall_adr", o_adr, 15'h0456);
         check("stall_busy", o_reqBusy, 4'hF);
      end
      @(posedge clk);
      #2;
      i_busy = 1'b0;
      waitIdle("stall_accept");
      ret_q.push_back({3'd1, 32'h57A11001});
      beat(32'h57A11001);
      // Pointer advanced once past requester 1: requester 2 beats 0
      enq(0, mk(1'b1, 2'b00, 15'h0B00, 3'd0, 16'h0001, 32'h00000B00));
      enq(2, mk(1'b1, 2'b00, 15'h0B02, 3'd0, 16'h0002, 32'h00000B02));
      expectCmd(2, mk(1'b1, 2'b00, 15'h0B02, 3'd0, 16'h0002, 32'h00000B02));
      expectCmd(0, mk(1'b1, 2'b00, 15'h0B00, 3'd0, 16'h0001, 32'h00000B00));
      waitIdle("ptr_after_stall");

      // Tag full: eight two-beat reads, interleaved 1,2,1,2,...
      for (int i = 0; i < 4; i++) begin
         enq(1, mk(1'b0, 2'b10, 15'(32'h100 + i), 3'd0, 16'h0, 32'h11000000 + i));
         enq(2, mk(1'b0, 2'b10, 15'(32'h200 + i), 3'd0, 16'h0, 32'h22000000 + i));
         expectCmd(1, mk(1'b0, 2'b10, 15'(32'h100 + i), 3'd0, 16'h0, 32'h11000000 + i));
         expectCmd(2, mk(1'b0, 2'b10, 15'(32'h200 + i), 3'd0, 16'h0, 32'h22000000 + i));
      end
      waitIdle("fill_tags");
      check("tagfull_set", o_tagFull, 1);
      enq(3, mk(1'b0, 2'b11, 15'h0333, 3'd7, 16'h0, 32'h33333333));
      enq(0, mk(1'b1, 2'b01, 15'h0444, 3'd1, 16'hBEEF, 32'h44444444));
      expectCmd(0, mk(1'b1, 2'b01, 15'h0444, 3'd1, 16'hBEEF, 32'h44444444));
      expectCmd(3, mk(1'b0, 2'b11, 15'h0333, 3'd7, 16'h0, 32'h33333333));
      tick(8);
      @(negedge clk);
      check("tagfull_read_blocked", o_command, 0);
      check("tagfull_held", o_tagFull, 1);
      check("tagfull_write_went", exp_q.size(), 1);
      @(posedge clk);
      #2;
      for (int i = 0; i < 8; i++) begin
         for (int b = 0; b < 2; b++) begin
            dws[2*i+b]  = 32'hA0000000 | (i << 8) | b;
            rets[2*i+b] = {((i % 2) == 0) ? 3'd1 : 3'd2, dws[2*i+b]};
         end
      end
      dws[16]  = 32'hC3C3C3C3;
      rets[16] = {3'd3, 32'hC3C3C3C3};
      for (int j = 0; j < 17; j++) ret_q.push_back(rets[j]);
      for (int j = 0; j < 17; j++) beat(dws[j]);
      waitIdle("drain_tags");
      check("tagfull_clear", o_tagFull, 0);
      check("drain_cmds_done", exp_q.size(), 0);
      check("drain_rets_done", ret_q.size(), 0);

      // Asynchronous reset in ISSUE with three tags outstanding
      for (int i = 0; i < 3; i++) begin
         enq(1, mk(1'b0, 2'b01, 15'(32'h500 + i), 3'd0, 16'h0, 32'h55000000 + i));
         expectCmd(1, mk(1'b0, 2'b01, 15'(32'h500 + i), 3'd0, 16'h0, 32'h55000000 + i));
      end
      waitIdle("pre_reset_reads");
      i_busy = 1'b1;
      enq(2, mk(1'b0, 2'b01, 15'h0666, 3'd0, 16'h0, 32'h66666666));
      waitCommand("pre_reset_issue");
      check("pre_reset_state", o_dbgState, 1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("areset_command", o_command, 0);
      check("areset_busy", o_reqBusy, 4'hF);
      check("areset_state", o_dbgState, 0);
      check("areset_tagfull", o_tagFull, 0);
      clearBench();
      tick(2);
      rst_n = 1'b1;
      tick(1);
      beat(32'h1A7E0000);
      tick(1);
      check("late_data_orphan", o_errOrphan, 1);
      check("end_cmds_done", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
